// File: rtl/disp_arb_pkg.sv
// Shared types and derived constants for the display arbiter.
// Owner encoding doubles as the FSM state so it can be observed directly.
package disp_arb_pkg;

    typedef enum logic [1:0] {
        OWN_COUNT = 2'd0,
        OWN_EDIT  = 2'd1,
        OWN_ALERT = 2'd2
    } own_e;

    localparam int CLK_HZ_DEF    = 10_000_000;
    localparam int FLASH_HZ_DEF  = 2;
    localparam int MS_DIV        = CLK_HZ_DEF / 1000;
    localparam int FLASH_HALF_MS = 500 / FLASH_HZ_DEF;

    // Per-instance versions of the constants above, for parameterised tops.
    function automatic int ms_div_of(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int flash_half_ms_of(input int flash_hz);
        return 500 / flash_hz;
    endfunction

endpackage

// File: rtl/disp_arbiter_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV cycles, restartable via clr.
module ms_tick_gen #(
    parameter int DIV = 10_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            W    = $clog2(DIV + 1);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tick is taken from the count alone so clr never feeds back into it.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/disp_arbiter.sv
// Fixed-priority display owner (ALERT > EDIT > COUNT) with registered outputs.
// ALERT state, flash and alert timer exist only when DISP_ARB_ALERT_EN is defined.
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int CLK_HZ   = 10_000_000,
    parameter int HOLD_MS  = 1000,
    parameter int FLASH_HZ = 2,
    parameter int ALERT_S  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_tens,
    input  logic [3:0] cnt_ones,
    input  logic       edit_p,
    input  logic [3:0] edit_tens,
    input  logic [3:0] edit_ones,
    input  logic       expire_p,
    input  logic       ack_p,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones,
    output logic       out_blank,
    output logic [1:0] owner
);

    localparam int MS_DIV_P = ms_div_of(CLK_HZ);
`ifdef DISP_ARB_ALERT_EN
    localparam int ALERT_MS = ALERT_S * 1000;
    localparam int MS_MAX   = (ALERT_MS > HOLD_MS) ? ALERT_MS : HOLD_MS;
`else
    localparam int MS_MAX   = HOLD_MS;
`endif
    localparam int            MW        = $clog2(MS_MAX + 1);
    localparam logic [MW-1:0] MS_SAT    = MW'(MS_MAX);
    localparam logic [MW-1:0] HOLD_LAST = MW'(HOLD_MS - 1);

    own_e         r_state, w_state_nx;
    logic [3:0]   r_tens, r_ones, w_tens_nx, w_ones_nx;
    logic         r_blank, w_blank_nx;
    logic         w_restart, w_clr, w_tick, w_hold_end;
    logic [MW-1:0] r_ms;

    // Any state entry or timer restart realigns the ms grid to this edge.
    assign w_clr      = (w_state_nx != r_state) || w_restart;
    assign w_hold_end = w_tick && (r_ms == HOLD_LAST);

    ms_tick_gen #(.DIV(MS_DIV_P)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ms <= '0;
        end else if (w_clr) begin
            r_ms <= '0;
        end else if (w_tick && (r_ms != MS_SAT)) begin
            r_ms <= r_ms + 1'b1;
        end
    end

`ifdef DISP_ARB_ALERT_EN
    localparam int            HALF_MS    = flash_half_ms_of(FLASH_HZ);
    localparam int            FW         = $clog2(HALF_MS + 1);
    localparam logic [FW-1:0] FL_LAST    = FW'(HALF_MS - 1);
    localparam logic [MW-1:0] ALERT_LAST = MW'(ALERT_MS - 1);

    logic [FW-1:0] r_fl;
    logic          w_flash_end, w_alert_end;

    assign w_flash_end = w_tick && (r_fl == FL_LAST);
    assign w_alert_end = w_tick && (r_ms == ALERT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fl <= '0;
        end else if (w_clr || w_flash_end) begin
            r_fl <= '0;
        end else if (w_tick) begin
            r_fl <= r_fl + 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{expire_p, ack_p, FLASH_HZ[0], ALERT_S[0]};
`endif

    always_comb begin
        w_state_nx = r_state;
        w_tens_nx  = r_tens;
        w_ones_nx  = r_ones;
        w_blank_nx = r_blank;
        w_restart  = 1'b0;
        case (r_state)
            OWN_COUNT: begin
                w_tens_nx = cnt_tens;
                w_ones_nx = cnt_ones;
`ifdef DISP_ARB_ALERT_EN
                if (expire_p) begin
                    w_state_nx = OWN_ALERT;
                    w_blank_nx = 1'b0;
                end else
`endif
                if (edit_p) begin
                    w_state_nx = OWN_EDIT;
                    w_tens_nx  = edit_tens;
                    w_ones_nx  = edit_ones;
                end
            end
            OWN_EDIT: begin
`ifdef DISP_ARB_ALERT_EN
                if (expire_p) begin
                    w_state_nx = OWN_ALERT;
                    w_tens_nx  = cnt_tens;
                    w_ones_nx  = cnt_ones;
                    w_blank_nx = 1'b0;
                end else
`endif
                if (edit_p) begin
                    w_restart = 1'b1;
                    w_tens_nx = edit_tens;
                    w_ones_nx = edit_ones;
                end else if (w_hold_end) begin
                    w_state_nx = OWN_COUNT;
                    w_tens_nx  = cnt_tens;
                    w_ones_nx  = cnt_ones;
                end
            end
`ifdef DISP_ARB_ALERT_EN
            OWN_ALERT: begin
                // Ack outranks a coincident expire; edit is ignored here.
                if (ack_p || (!expire_p && w_alert_end)) begin
                    w_state_nx = OWN_COUNT;
                    w_tens_nx  = cnt_tens;
                    w_ones_nx  = cnt_ones;
                    w_blank_nx = 1'b0;
                end else if (expire_p) begin
                    w_restart  = 1'b1;
                    w_blank_nx = 1'b0;
                end else if (w_flash_end) begin
                    w_blank_nx = ~r_blank;
                end
            end
`endif
            default: begin
                w_state_nx = OWN_COUNT;
                w_blank_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OWN_COUNT;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tens  <= w_tens_nx;
            r_ones  <= w_ones_nx;
            r_blank <= w_blank_nx;
        end
    end

    assign out_tens  = r_tens;
    assign out_ones  = r_ones;
    assign out_blank = r_blank;
    assign owner     = r_state;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: cycle-counting reference model plus directed and random stimulus.
module tb_disp_arbiter;

    localparam int CLK_HZ    = 10_000;
    localparam int HOLD_MS   = 5;
    localparam int FLASH_HZ  = 100;
    localparam int ALERT_S   = 1;
    localparam int CYC_MS    = CLK_HZ / 1000;
    localparam int HOLD_CYC  = HOLD_MS * CYC_MS;
    localparam int HALF_CYC  = (500 / FLASH_HZ) * CYC_MS;
    localparam int ALERT_CYC = ALERT_S * 1000 * CYC_MS;
`ifdef DISP_ARB_ALERT_EN
    localparam bit ALERT_EN = 1'b1;
`else
    localparam bit ALERT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt_tens = 4'd4, cnt_ones = 4'd2;
    logic       edit_p = 1'b0, expire_p = 1'b0, ack_p = 1'b0;
    logic [3:0] edit_tens = 4'd0, edit_ones = 4'd0;
    logic [3:0] out_tens, out_ones;
    logic       out_blank;
    logic [1:0] owner;

    int n_chk  = 0;
    int n_pass = 0;

    disp_arbiter #(
        .CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS), .FLASH_HZ(FLASH_HZ), .ALERT_S(ALERT_S)
    ) dut (
        .clk(clk), .rst(rst),
        .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
        .edit_p(edit_p), .edit_tens(edit_tens), .edit_ones(edit_ones),
        .expire_p(expire_p), .ack_p(ack_p),
        .out_tens(out_tens), .out_ones(out_ones),
        .out_blank(out_blank), .owner(owner)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference model: mode plus cycles-left / cycles-since-entry counters.
    int         m_mode;
    logic [3:0] m_t, m_o;
    int         m_left, m_age;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_t <= 4'd0; m_o <= 4'd0; m_left <= 0; m_age <= 0;
        end else begin
            case (m_mode)
                0: begin
                    if (ALERT_EN && expire_p) begin
                        m_mode <= 2; m_age <= 0; m_t <= cnt_tens; m_o <= cnt_ones;
                    end else if (edit_p) begin
                        m_mode <= 1; m_left <= HOLD_CYC; m_t <= edit_tens; m_o <= edit_ones;
                    end else begin
                        m_t <= cnt_tens; m_o <= cnt_ones;
                    end
                end
                1: begin
                    if (ALERT_EN && expire_p) begin
                        m_mode <= 2; m_age <= 0; m_t <= cnt_tens; m_o <= cnt_ones;
                    end else if (edit_p) begin
                        m_left <= HOLD_CYC; m_t <= edit_tens; m_o <= edit_ones;
                    end else if (m_left == 1) begin
                        m_mode <= 0; m_t <= cnt_tens; m_o <= cnt_ones;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: begin
                    if (ack_p) begin
                        m_mode <= 0; m_t <= cnt_tens; m_o <= cnt_ones;
                    end else if (expire_p) begin
                        m_age <= 0;
                    end else if (m_age + 1 == ALERT_CYC) begin
                        m_mode <= 0; m_t <= cnt_tens; m_o <= cnt_ones;
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Scoreboard: compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic exp_blank;
        exp_blank = (m_mode == 2) && (((m_age / HALF_CYC) % 2) == 1);
        chk("m_owner", {6'd0, owner}, 8'(m_mode));
        chk("m_tens",  {4'd0, out_tens}, {4'd0, m_t});
        chk("m_ones",  {4'd0, out_ones}, {4'd0, m_o});
        chk("m_blank", {7'd0, out_blank}, {7'd0, exp_blank});
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ed, input logic ex, input logic ak,
                         input logic [3:0] et, input logic [3:0] eo);
        edit_p = ed; expire_p = ex; ack_p = ak; edit_tens = et; edit_ones = eo;
        tick(1);
        edit_p = 1'b0; expire_p = 1'b0; ack_p = 1'b0;
    endtask

    initial begin
        // Reset held with live value 4/2
        tick(3);
        chk("rst_owner", {6'd0, owner}, 8'd0);
        chk("rst_tens",  {4'd0, out_tens}, 8'd0);
        chk("rst_ones",  {4'd0, out_ones}, 8'd0);
        chk("rst_blank", {7'd0, out_blank}, 8'd0);
        rst = 1'b1;
        tick(1);
        chk("rel_tens", {4'd0, out_tens}, 8'd4);
        chk("rel_ones", {4'd0, out_ones}, 8'd2);

        // Edit hold of exactly 50 cycles
        pulse(1'b1, 1'b0, 1'b0, 4'd3, 4'd7);
        chk("ed_owner", {6'd0, owner}, 8'd1);
        chk("ed_tens",  {4'd0, out_tens}, 8'd3);
        chk("ed_ones",  {4'd0, out_ones}, 8'd7);
        cnt_tens = 4'd6; cnt_ones = 4'd1;
        tick(49);
        chk("ed_hold49", {6'd0, owner}, 8'd1);
        tick(1);
        chk("ed_end_owner", {6'd0, owner}, 8'd0);
        chk("ed_end_tens",  {4'd0, out_tens}, 8'd6);

        // Re-edit at cycle 30 stretches to 80 cycles
        pulse(1'b1, 1'b0, 1'b0, 4'd3, 4'd7);
        tick(29);
        pulse(1'b1, 1'b0, 1'b0, 4'd1, 4'd5);
        chk("re_tens", {4'd0, out_tens}, 8'd1);
        chk("re_ones", {4'd0, out_ones}, 8'd5);
        tick(49);
        chk("re_hold79", {6'd0, owner}, 8'd1);
        tick(1);
        chk("re_end80", {6'd0, owner}, 8'd0);

`ifdef DISP_ARB_ALERT_EN
        cnt_tens = 4'd0; cnt_ones = 4'd0;
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("al_owner", {6'd0, owner}, 8'd2);
        chk("al_blank0", {7'd0, out_blank}, 8'd0);
        tick(49);
        chk("al_blank49", {7'd0, out_blank}, 8'd0);
        tick(1);
        chk("al_blank50", {7'd0, out_blank}, 8'd1);
        tick(49);
        chk("al_blank99", {7'd0, out_blank}, 8'd1);
        tick(1);
        chk("al_blank100", {7'd0, out_blank}, 8'd0);
        tick(9899);
        chk("al_9999", {6'd0, owner}, 8'd2);
        tick(1);
        chk("al_10000", {6'd0, owner}, 8'd0);
        chk("al_10000_blank", {7'd0, out_blank}, 8'd0);

        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        tick(119);
        pulse(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        chk("ack_owner", {6'd0, owner}, 8'd0);
        chk("ack_blank", {7'd0, out_blank}, 8'd0);

        cnt_tens = 4'd2; cnt_ones = 4'd3;
        pulse(1'b1, 1'b1, 1'b0, 4'd9, 4'd9);
        chk("sim_owner", {6'd0, owner}, 8'd2);
        chk("sim_tens",  {4'd0, out_tens}, 8'd2);
        chk("sim_ones",  {4'd0, out_ones}, 8'd3);
        pulse(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        chk("ackexp_owner", {6'd0, owner}, 8'd0);
`else
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("off_owner", {6'd0, owner}, 8'd0);
        chk("off_blank", {7'd0, out_blank}, 8'd0);
        pulse(1'b1, 1'b0, 1'b0, 4'd8, 4'd8);
        pulse(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        chk("off_edit_kept", {6'd0, owner}, 8'd1);
        chk("off_edit_tens", {4'd0, out_tens}, 8'd8);
`endif

        // Random traffic, with one mid-cycle async reset
        for (int i = 0; i < 4000; i++) begin
            cnt_tens  = 4'($urandom_range(0, 15));
            cnt_ones  = 4'($urandom_range(0, 15));
            edit_tens = 4'($urandom_range(0, 15));
            edit_ones = 4'($urandom_range(0, 15));
            edit_p    = ($urandom_range(0, 39) == 0);
            expire_p  = ($urandom_range(0, 199) == 0);
            ack_p     = ($urandom_range(0, 79) == 0);
            if (i == 2000) begin
                #2 rst = 1'b0;
                tick(2);
                rst = 1'b1;
            end
            tick(1);
        end
        edit_p = 1'b0; expire_p = 1'b0; ack_p = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
